// File: rtl/tomasulo_pkg.sv
// Shared encodings for the Tomasulo core: MIPS opcode/funct fields, ALU ops,
// reservation-station class indices and destination-register select.
package tomasulo_pkg;

  localparam logic [5:0] OP_RFMT   = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;

  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_MULU = 6'h19;
  localparam logic [5:0] FUNC_DIVU = 6'h1B;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } aluop_e;

  localparam int CLS_ADDSUB = 0;
  localparam int CLS_MUL    = 1;
  localparam int CLS_DIV    = 2;

  typedef enum logic {
    REGDST_RT = 1'b0,
    REGDST_RD = 1'b1
  } regdst_e;

endpackage

// File: rtl/issue_decode.sv
// Combinational decode of the queue head: one-hot class, ALU op, destination,
// immediate select and an illegal flag. Zero latency, no flow control.
import tomasulo_pkg::*;

module issue_decode #(
  parameter int NUM_CLASS = 3
) (
  input  logic [5:0]           i_op,
  input  logic [5:0]           i_funct,
  input  logic [4:0]           i_rt,
  input  logic [4:0]           i_rd,
  output logic [NUM_CLASS-1:0] o_cls,
  output aluop_e               o_aluop,
  output logic [4:0]           o_dst,
  output logic                 o_use_imm,
  output logic                 o_illegal
);

  regdst_e w_regdst;

  always_comb begin
    o_cls     = '0;
    o_aluop   = ALU_ADD;
    w_regdst  = REGDST_RD;
    o_use_imm = 1'b0;
    o_illegal = 1'b1;
    case (i_op)
      OP_RFMT: begin
        case (i_funct)
          FUNC_ADD: begin
            o_cls[CLS_ADDSUB] = 1'b1;
            o_illegal         = 1'b0;
          end
          FUNC_SUB: begin
            o_cls[CLS_ADDSUB] = 1'b1;
            o_aluop           = ALU_SUB;
            o_illegal         = 1'b0;
          end
          FUNC_AND: begin
            o_cls[CLS_ADDSUB] = 1'b1;
            o_aluop           = ALU_AND;
            o_illegal         = 1'b0;
          end
          FUNC_OR: begin
            o_cls[CLS_ADDSUB] = 1'b1;
            o_aluop           = ALU_OR;
            o_illegal         = 1'b0;
          end
          FUNC_MULU: begin
            o_cls[CLS_MUL] = 1'b1;
            o_illegal      = 1'b0;
          end
          FUNC_DIVU: begin
            o_cls[CLS_DIV] = 1'b1;
            o_illegal      = 1'b0;
          end
          default: ;
        endcase
      end
      OP_ADDI: begin
        o_cls[CLS_ADDSUB] = 1'b1;
        w_regdst          = REGDST_RT;
        o_use_imm         = 1'b1;
        o_illegal         = 1'b0;
      end
      default: ;
    endcase
  end

  assign o_dst = (w_regdst == REGDST_RD) ? i_rd : i_rt;

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: DEPTH-entry queue, head decode, one registered dispatch per cycle.
// Accept-to-issue latency 1 cycle; in_ready = count<DEPTH, head holds while its class is full.
import tomasulo_pkg::*;

module issue_unit #(
  parameter int DEPTH     = 4,
  parameter int NUM_CLASS = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  output logic                 in_ready,
  input  logic                 flush,
  input  logic [NUM_CLASS-1:0] rs_full,
  output logic                 issue_valid,
  output logic [NUM_CLASS-1:0] issue_en,
  output logic [1:0]           issue_aluop,
  output logic [4:0]           issue_rs,
  output logic [4:0]           issue_rt,
  output logic [4:0]           issue_dst,
  output logic [15:0]          issue_imm,
  output logic                 issue_use_imm,
  output logic                 illegal,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [31:0]          r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PW:0]          r_count;
  logic                 r_valid;
  logic [NUM_CLASS-1:0] r_en;
  logic [1:0]           r_aluop;
  logic [4:0]           r_rs, r_rt, r_dst;
  logic [15:0]          r_imm;
  logic                 r_use_imm;
  logic                 r_illegal;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic [31:0]          w_head;
  logic [NUM_CLASS-1:0] w_cls;
  aluop_e               w_aluop;
  logic [4:0]           w_dst;
  logic                 w_use_imm, w_illegal;
  logic                 w_active, w_blocked, w_push, w_pop, w_issue, w_stall;

  assign w_head = r_mem[r_rd_ptr];

  issue_decode #(.NUM_CLASS(NUM_CLASS)) u_decode (
    .i_op      (w_head[31:26]),
    .i_funct   (w_head[5:0]),
    .i_rt      (w_head[20:16]),
    .i_rd      (w_head[15:11]),
    .o_cls     (w_cls),
    .o_aluop   (w_aluop),
    .o_dst     (w_dst),
    .o_use_imm (w_use_imm),
    .o_illegal (w_illegal)
  );

  // Pop decision only considers the head when the queue is non-empty and not being flushed.
  assign w_active  = (r_count != '0) && !flush;
  assign w_blocked = |(w_cls & rs_full);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = w_active && (w_illegal || !w_blocked);
  assign w_issue   = w_active && !w_illegal && !w_blocked;
  assign w_stall   = w_active && !w_illegal && w_blocked;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_en        <= '0;
      r_aluop     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_dst       <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_illegal   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: ;
        endcase
      end
      r_valid <= w_issue;
      r_en    <= w_issue ? w_cls : '0;
      // Data fields keep their last values across stalls and bubbles.
      if (w_issue) begin
        r_aluop   <= w_aluop;
        r_rs      <= w_head[25:21];
        r_rt      <= w_head[20:16];
        r_dst     <= w_dst;
        r_imm     <= w_head[15:0];
        r_use_imm <= w_use_imm;
      end
      if (w_pop && w_illegal) r_illegal <= 1'b1;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready      = (r_count != CNT_FULL);
  assign issue_valid   = r_valid;
  assign issue_en      = r_en;
  assign issue_aluop   = r_aluop;
  assign issue_rs      = r_rs;
  assign issue_rt      = r_rt;
  assign issue_dst     = r_dst;
  assign issue_imm     = r_imm;
  assign issue_use_imm = r_use_imm;
  assign illegal       = r_illegal;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: latency, decode, stall/back-pressure, illegal drop, flush, reset.
module tb_issue_unit;

  localparam int DEPTH = 4;
  localparam int NC    = 3;
  localparam int CW    = 16;

  localparam logic [31:0] I_ADD   = 32'h00221820;  // add  $3,$1,$2
  localparam logic [31:0] I_MULTU = 32'h00220019;  // multu $1,$2
  localparam logic [31:0] I_DIVU  = 32'h0022001B;  // divu $1,$2
  localparam logic [31:0] I_ADDI  = 32'h20850007;  // addi $5,$4,7
  localparam logic [31:0] I_BAD   = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] I_SUB   = 32'h00223022;  // sub  $6,$1,$2
  localparam logic [31:0] I_OR    = 32'h00223825;  // or   $7,$1,$2

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          flush;
  logic [NC-1:0] rs_full;
  logic          issue_valid;
  logic [NC-1:0] issue_en;
  logic [1:0]    issue_aluop;
  logic [4:0]    issue_rs, issue_rt, issue_dst;
  logic [15:0]   issue_imm;
  logic          issue_use_imm;
  logic          illegal;
  logic [CW-1:0] stall_cnt;

  int n_chk = 0;
  int n_bad = 0;

  issue_unit #(.DEPTH(DEPTH), .NUM_CLASS(NC), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .rs_full       (rs_full),
    .issue_valid   (issue_valid),
    .issue_en      (issue_en),
    .issue_aluop   (issue_aluop),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_dst     (issue_dst),
    .issue_imm     (issue_imm),
    .issue_use_imm (issue_use_imm),
    .illegal       (illegal),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1ns later, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    flush    = 1'b0;
    rs_full  = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_en",    32'(issue_en), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_ill",   32'(illegal), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_dst",   32'(issue_dst), 0);

    // Back-to-back add then multu
    in_valid = 1'b1; in_instr = I_ADD;
    tick();
    chk("lat_no_bypass", 32'(issue_valid), 0);
    in_instr = I_MULTU;
    tick();
    chk("add_valid", 32'(issue_valid), 1);
    chk("add_en",    32'(issue_en), 32'b001);
    chk("add_dst",   32'(issue_dst), 3);
    chk("add_alu",   32'(issue_aluop), 0);
    chk("add_rs",    32'(issue_rs), 1);
    chk("add_rt",    32'(issue_rt), 2);
    in_valid = 1'b0;
    tick();
    chk("mul_valid", 32'(issue_valid), 1);
    chk("mul_en",    32'(issue_en), 32'b010);
    chk("mul_alu",   32'(issue_aluop), 0);
    tick();
    chk("idle_valid", 32'(issue_valid), 0);
    chk("idle_en",    32'(issue_en), 0);

    // addi
    in_valid = 1'b1; in_instr = I_ADDI;
    tick();
    in_valid = 1'b0;
    tick();
    chk("addi_valid", 32'(issue_valid), 1);
    chk("addi_en",    32'(issue_en), 32'b001);
    chk("addi_imm_f", 32'(issue_use_imm), 1);
    chk("addi_dst",   32'(issue_dst), 5);
    chk("addi_imm",   32'(issue_imm), 32'h0007);
    chk("addi_rs",    32'(issue_rs), 4);
    tick();

    // divu stalled 10 cycles while more adds queue behind it
    rs_full = 3'b100;
    in_valid = 1'b1; in_instr = I_DIVU;
    tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < DEPTH);
      in_instr = 32'h00220020 | (32'(8 + i) << 11);
      if (i == 3) chk("full_ready_lo", 32'(in_ready), 0);
      tick();
      chk($sformatf("hold_valid%0d", i), 32'(issue_valid), 0);
      chk($sformatf("hold_data%0d", i), 32'(issue_use_imm), 1);
    end
    in_valid = 1'b0;
    chk("hold_ready", 32'(in_ready), 0);
    chk("hold_stall", 32'(stall_cnt), 10);
    rs_full = 3'b000;
    tick();
    chk("divu_valid", 32'(issue_valid), 1);
    chk("divu_en",    32'(issue_en), 32'b100);
    chk("divu_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain_en%0d", i),  32'(issue_en), 32'b001);
      chk($sformatf("drain_dst%0d", i), 32'(issue_dst), 32'(8 + i));
    end
    tick();
    chk("drain_done", 32'(issue_valid), 0);
    chk("stall_keep", 32'(stall_cnt), 10);

    // Illegal instruction followed by a legal one
    in_valid = 1'b1; in_instr = I_BAD;
    tick();
    in_instr = I_SUB;
    tick();
    chk("ill_flag",  32'(illegal), 1);
    chk("ill_valid", 32'(issue_valid), 0);
    in_valid = 1'b0;
    tick();
    chk("sub_valid", 32'(issue_valid), 1);
    chk("sub_alu",   32'(issue_aluop), 1);
    chk("sub_dst",   32'(issue_dst), 6);
    tick();
    chk("ill_sticky", 32'(illegal), 1);

    // Flush with three queued entries and a same-cycle push
    rs_full = 3'b111;
    in_valid = 1'b1; in_instr = I_ADD;
    tick();
    tick();
    tick();
    chk("pre_flush_stall", 32'(stall_cnt), 12);
    flush = 1'b1; in_instr = I_OR;
    tick();
    flush = 1'b0; in_valid = 1'b0; rs_full = 3'b000;
    chk("flush_valid", 32'(issue_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    chk("flush_stall", 32'(stall_cnt), 12);
    chk("flush_ill",   32'(illegal), 1);
    w = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      w = w | 32'(issue_valid);
    end
    chk("flush_no_issue", w, 0);

    // Reset mid-stall
    rs_full = 3'b001;
    in_valid = 1'b1; in_instr = I_ADD;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; rs_full = 3'b000;
    chk("mrst_valid", 32'(issue_valid), 0);
    chk("mrst_en",    32'(issue_en), 0);
    chk("mrst_alu",   32'(issue_aluop), 0);
    chk("mrst_regs",  {17'd0, issue_rs, issue_rt, issue_dst}, 0);
    chk("mrst_imm",   32'(issue_imm), 0);
    chk("mrst_uimm",  32'(issue_use_imm), 0);
    chk("mrst_ill",   32'(illegal), 0);
    chk("mrst_stall", 32'(stall_cnt), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    w = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      w = w | 32'(issue_valid);
    end
    chk("mrst_no_stale", w, 0);
    in_valid = 1'b1; in_instr = I_OR;
    tick();
    in_valid = 1'b0;
    tick();
    chk("or_valid", 32'(issue_valid), 1);
    chk("or_alu",   32'(issue_aluop), 3);
    chk("or_dst",   32'(issue_dst), 7);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

Parametrised in-order issue stage for the Tomasulo core. It buffers fetched instructions in a DEPTH-entry queue and decodes the head into ALU operation, target functional-unit class and destination register. It dispatches at most one instruction per cycle to the reservation-station class whose full flag is clear. It sits between fetch and the reservation stations, and adds buffering, back-pressure, flush, illegal-instruction filtering and stall accounting.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- NUM_CLASS, 3, reservation-station classes (0 addsub, 1 multiply, 2 divide); ≥3
- CNT_W, 16, stall counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  fetch presents in_instr
- in_instr  in  32  MIPS instruction word
- in_ready  out  1  queue can accept; equals count<DEPTH
- flush  in  1  discard queue contents and any pending issue
- rs_full  in  NUM_CLASS  per-class reservation-station full flag
- issue_valid  out  1  one-cycle dispatch pulse
- issue_en  out  NUM_CLASS  one-hot class select; 0 when !issue_valid
- issue_aluop  out  2  0 add, 1 sub, 2 and, 3 or
- issue_rs, issue_rt, issue_dst  out  5 each  source and destination register numbers
- issue_imm  out  16  immediate field
- issue_use_imm  out  1  second operand is immediate
- illegal  out  1  sticky: an undecodable instruction was dropped
- stall_cnt  out  CNT_W  saturating count of structural-stall cycles

## Operation
- Push: in_valid && in_ready && !flush writes in_instr at the tail and increments count.
- Head decode is combinational:
  - op 0x00 with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or → class 0, aluop per funct, dst = rd, use_imm = 0.
  - funct 0x19 multu → class 1, aluop 0. funct 0x1B divu → class 2, aluop 0.
  - op 0x08 addi → class 0, aluop 0, dst = rt, use_imm = 1.
  - Anything else is illegal.
- Pop rule, in priority order, for any cycle with count>0 and !flush:
  1. Head illegal: pop it, issue nothing, set illegal.
  2. Head legal and rs_full[class]==0: pop it and register the decode onto the issue_* outputs.
  3. Head legal and rs_full[class]==1: hold; stall_cnt increments and saturates at all-ones.
- Empty queue: issue_valid = 0 and stall_cnt holds.
- Push and pop in the same cycle: count is unchanged. in_ready depends only on registered count; there is no pass-through while full.
- flush: next cycle count = 0 and issue_valid = 0. A same-cycle push is discarded. illegal and stall_cnt are not cleared by flush.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- rst: count, pointers, issue_valid, issue_en, issue_aluop, issue_rs/rt/dst, issue_imm, issue_use_imm, illegal and stall_cnt all become 0; in_ready becomes 1. Reset mid-stall drops every queued instruction.

## Timing
- Instruction accepted at edge E0 is head in the following cycle. If its class is not full in that cycle, it pops at E1 and issue_valid is high for exactly the cycle after E1. Minimum accept-to-issue latency is 1 cycle; there is no empty-queue bypass.
- Sustained throughput is one issue per cycle while classes are free.
- rs_full is sampled in the same cycle as the pop decision. The reservation station must assert full one cycle before it actually overflows, because one issue may already be registered.
- in_ready deasserts in the cycle after the DEPTH-th push, unless that same cycle popped.
- A stall holds the issue_* data fields at their last values with issue_valid = 0.

## Structure
- Shared package `tomasulo_pkg`:
  - opcode/funct constants: OP_RFMT, OP_ADDI, FUNC_ADD/SUB/AND/OR/MULU/DIVU
  - ALU op encodings: ALU_ADD/SUB/AND/OR
  - class indices: CLS_ADDSUB = 0, CLS_MUL = 1, CLS_DIV = 2
  - RegDst encodings
- Sub-module `issue_decode`: purely combinational head decode producing class, aluop, dst, use_imm and illegal.
- Queue storage, pointers, counters and issue registers live in the top module.

## Test plan
- Back-to-back push of add $3,$1,$2 (0x00221820) then multu, all rs_full = 0 → issue_valid on cycles 2 and 3; issue_en 001 then 010; first issue has issue_dst = 3, aluop 0.
- addi $5,$4,7 with rs_full = 000 → issue_en 001, use_imm = 1, dst = 5, imm = 0x0007.
- divu at head with rs_full = 100 held 10 cycles, then released → stall_cnt = 10, no issue during the hold, divu issues the cycle after release. Push DEPTH extra instructions during the hold → in_ready = 0 once count = DEPTH.
- Opcode 0x3F at head → dropped, illegal = 1 sticky, no issue_valid. The following legal instruction issues normally.
- Queue holding 3 entries, flush asserted together with in_valid → count = 0 and issue_valid = 0 next cycle; the flushed-cycle instruction never issues; stall_cnt is unchanged.
- rst asserted mid-stream → every output is zero next cycle, in_ready = 1, and no stale entry issues afterward.
